// File: rtl/execute_forwarding_history_if.sv
// Bundle of writeback, source-operand and forwarded-result signals for the
// execute-stage forwarding history. Producer/consumer sides are split by modport.
interface execute_forwarding_history_if #(
    parameter int P_SRC_NUM = 2,
    parameter int P_DEPTH   = 2
);
    logic                    iRESET_SYNC;
    logic                    iADVANCE;
    logic                    iWB_GR_VALID;
    logic [31:0]             iWB_GR_DATA;
    logic [4:0]              iWB_GR_DEST;
    logic                    iWB_GR_DEST_SYSREG;
    logic                    iWB_SPR_VALID;
    logic [31:0]             iWB_SPR_DATA;
    logic                    iWB_FRCR_VALID;
    logic [63:0]             iWB_FRCR_DATA;
    logic [P_SRC_NUM-1:0]    iSRC_IMM;
    logic [P_SRC_NUM-1:0]    iSRC_SYSREG;
    logic [5*P_SRC_NUM-1:0]  iSRC_POINTER;
    logic [32*P_SRC_NUM-1:0] iSRC_DATA;
    logic [31:0]             iSRC_SPR;
    logic [31:0]             iSRC_PSR;
    logic [32*P_SRC_NUM-1:0] oSRC_DATA;
    logic [P_SRC_NUM-1:0]    oSRC_HIT;
    logic [31:0]             oSPR;
    logic [31:0]             oPSR;
    logic [P_DEPTH-1:0]      oHIST_OCCUPIED;

    modport master (
        output iRESET_SYNC, iADVANCE,
        output iWB_GR_VALID, iWB_GR_DATA, iWB_GR_DEST, iWB_GR_DEST_SYSREG,
        output iWB_SPR_VALID, iWB_SPR_DATA, iWB_FRCR_VALID, iWB_FRCR_DATA,
        output iSRC_IMM, iSRC_SYSREG, iSRC_POINTER, iSRC_DATA, iSRC_SPR, iSRC_PSR,
        input  oSRC_DATA, oSRC_HIT, oSPR, oPSR, oHIST_OCCUPIED
    );

    modport slave (
        input  iRESET_SYNC, iADVANCE,
        input  iWB_GR_VALID, iWB_GR_DATA, iWB_GR_DEST, iWB_GR_DEST_SYSREG,
        input  iWB_SPR_VALID, iWB_SPR_DATA, iWB_FRCR_VALID, iWB_FRCR_DATA,
        input  iSRC_IMM, iSRC_SYSREG, iSRC_POINTER, iSRC_DATA, iSRC_SPR, iSRC_PSR,
        output oSRC_DATA, oSRC_HIT, oSPR, oPSR, oHIST_OCCUPIED
    );
endinterface

// File: rtl/execute_forwarding_history.sv
// Execute-stage operand forwarding: a P_DEPTH-deep shift history of writebacks
// searched newest-first (current inputs, slot 0 .. slot P_DEPTH-1, register file).
`ifndef SYSREG_PSR
`define SYSREG_PSR 5'h03
`endif
`ifndef SYSREG_SPR
`define SYSREG_SPR 5'h0F
`endif
`ifndef SYSREG_FRCLR
`define SYSREG_FRCLR 5'h16
`endif
`ifndef SYSREG_FRCHR
`define SYSREG_FRCHR 5'h17
`endif
`ifndef SYSREG_FRCR2FRCXR
`define SYSREG_FRCR2FRCXR 5'h1E
`endif

module execute_forwarding_history #(
    parameter int P_DEPTH   = 2,
    parameter int P_SRC_NUM = 2
) (
    input  logic iCLOCK,
    input  logic inRESET,
    execute_forwarding_history_if.slave bus
);
    localparam int N_LVL = P_DEPTH + 1;
    localparam logic [4:0] SYSREG_PSR        = `SYSREG_PSR;
    localparam logic [4:0] SYSREG_SPR        = `SYSREG_SPR;
    localparam logic [4:0] SYSREG_FRCLR      = `SYSREG_FRCLR;
    localparam logic [4:0] SYSREG_FRCHR      = `SYSREG_FRCHR;
    localparam logic [4:0] SYSREG_FRCR2FRCXR = `SYSREG_FRCR2FRCXR;

    typedef struct packed {
        logic        gr_valid;
        logic        gr_sysreg;
        logic [4:0]  gr_dest;
        logic [31:0] gr_data;
        logic        spr_valid;
        logic [31:0] spr_data;
        logic        frcr_valid;
        logic [63:0] frcr_data;
    } entry_t;

    entry_t slot_reg [P_DEPTH];
    entry_t wb_entry;
    entry_t lvl [N_LVL];

    logic [32*P_SRC_NUM-1:0] src_data_next;
    logic [P_SRC_NUM-1:0]    src_hit_next;
    logic [P_DEPTH-1:0]      occupied_next;
    logic [31:0]             spr_next;
    logic [31:0]             psr_next;

    always_comb begin
        wb_entry            = '0;
        wb_entry.gr_valid   = bus.iWB_GR_VALID;
        wb_entry.gr_sysreg  = bus.iWB_GR_DEST_SYSREG;
        wb_entry.gr_dest    = bus.iWB_GR_DEST;
        wb_entry.gr_data    = bus.iWB_GR_DATA;
        wb_entry.spr_valid  = bus.iWB_SPR_VALID;
        wb_entry.spr_data   = bus.iWB_SPR_DATA;
        wb_entry.frcr_valid = bus.iWB_FRCR_VALID;
        wb_entry.frcr_data  = bus.iWB_FRCR_DATA;
    end

    // Synchronous clear drops only the valid bits; stale data is never selected.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else if (bus.iRESET_SYNC) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                slot_reg[i].gr_valid   <= 1'b0;
                slot_reg[i].spr_valid  <= 1'b0;
                slot_reg[i].frcr_valid <= 1'b0;
            end
        end else if (bus.iADVANCE) begin
            slot_reg[0] <= wb_entry;
            for (int i = 1; i < P_DEPTH; i++) begin
                slot_reg[i] <= slot_reg[i-1];
            end
        end
    end

    // Level 0 is the in-flight writeback; level i+1 is history slot i.
    assign lvl[0] = wb_entry;

    genvar gi;
    generate
        for (gi = 0; gi < P_DEPTH; gi++) begin : g_lvl
            assign lvl[gi+1] = slot_reg[gi];
            assign occupied_next[gi] = slot_reg[gi].gr_valid | slot_reg[gi].spr_valid
                                     | slot_reg[gi].frcr_valid;
        end

        for (gi = 0; gi < P_SRC_NUM; gi++) begin : g_src
            logic [4:0]  ptr;
            logic        sys;
            logic [31:0] data_next;
            logic        hit_next;

            assign ptr = bus.iSRC_POINTER[5*gi +: 5];
            assign sys = bus.iSRC_SYSREG[gi];

            // Walk oldest to newest so the newest matching level ends up owning the result.
            always_comb begin
                data_next = bus.iSRC_DATA[32*gi +: 32];
                hit_next  = 1'b0;
                for (int l = N_LVL - 1; l >= 0; l--) begin
                    if (lvl[l].gr_valid && !bus.iSRC_IMM[gi]) begin
                        if (sys && ptr == SYSREG_SPR
                                && (lvl[l].spr_valid || lvl[l].gr_dest == SYSREG_SPR)) begin
                            data_next = lvl[l].spr_data;
                            hit_next  = 1'b1;
                        end else if (sys && ptr == SYSREG_FRCLR
                                && lvl[l].gr_dest == SYSREG_FRCR2FRCXR) begin
                            data_next = lvl[l].frcr_data[31:0];
                            hit_next  = 1'b1;
                        end else if (sys && ptr == SYSREG_FRCHR
                                && lvl[l].gr_dest == SYSREG_FRCR2FRCXR) begin
                            data_next = lvl[l].frcr_data[63:32];
                            hit_next  = 1'b1;
                        end else if (!sys && !lvl[l].gr_sysreg && ptr == lvl[l].gr_dest) begin
                            data_next = lvl[l].gr_data;
                            hit_next  = 1'b1;
                        end
                    end
                end
            end

            assign src_data_next[32*gi +: 32] = data_next;
            assign src_hit_next[gi]           = hit_next;
        end
    endgenerate

    always_comb begin
        spr_next = bus.iSRC_SPR;
        psr_next = bus.iSRC_PSR;
        for (int l = N_LVL - 1; l >= 0; l--) begin
            if (lvl[l].spr_valid) begin
                spr_next = lvl[l].spr_data;
            end
            if (lvl[l].gr_valid && lvl[l].gr_sysreg && lvl[l].gr_dest == SYSREG_PSR) begin
                psr_next = lvl[l].gr_data;
            end
        end
    end

    assign bus.oSRC_DATA      = src_data_next;
    assign bus.oSRC_HIT       = src_hit_next;
    assign bus.oSPR           = spr_next;
    assign bus.oPSR           = psr_next;
    assign bus.oHIST_OCCUPIED = occupied_next;
endmodule

// File: tb/tb_execute_forwarding_history.sv
// Directed bench for execute_forwarding_history (P_DEPTH=2, P_SRC_NUM=2).
module tb_execute_forwarding_history;
    localparam logic [4:0] PSR    = 5'h03;
    localparam logic [4:0] SPR    = 5'h0F;
    localparam logic [4:0] FRCLR  = 5'h16;
    localparam logic [4:0] FRCHR  = 5'h17;
    localparam logic [4:0] FRCR2X = 5'h1E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_forwarding_history_if #(.P_SRC_NUM(2), .P_DEPTH(2)) bus ();

    execute_forwarding_history #(.P_DEPTH(2), .P_SRC_NUM(2)) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .bus    (bus)
    );

    task automatic idle_inputs();
        bus.iRESET_SYNC = 0; bus.iADVANCE = 0;
        bus.iWB_GR_VALID = 0; bus.iWB_GR_DATA = 0; bus.iWB_GR_DEST = 0; bus.iWB_GR_DEST_SYSREG = 0;
        bus.iWB_SPR_VALID = 0; bus.iWB_SPR_DATA = 0; bus.iWB_FRCR_VALID = 0; bus.iWB_FRCR_DATA = 0;
        bus.iSRC_IMM = 0; bus.iSRC_SYSREG = 0; bus.iSRC_POINTER = 0;
        bus.iSRC_DATA = {32'h0000_2222, 32'h0000_1111};
        bus.iSRC_SPR = 32'h0000_2222; bus.iSRC_PSR = 32'h0;
    endtask

    task automatic gr_wb(input logic [4:0] dest, input logic [31:0] data, input logic sys);
        bus.iWB_GR_VALID = 1; bus.iWB_GR_DEST = dest; bus.iWB_GR_DATA = data;
        bus.iWB_GR_DEST_SYSREG = sys;
    endtask

    task automatic set_src(input int k, input logic sys, input logic [4:0] ptr, input logic [31:0] data);
        bus.iSRC_SYSREG[k] = sys;
        bus.iSRC_POINTER[5*k +: 5] = ptr;
        bus.iSRC_DATA[32*k +: 32] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_clear();
        idle_inputs();
        bus.iRESET_SYNC = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        set_src(0, 0, 5'd3, 32'h11);
        #2;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h11) begin
            failures++; $display("FAIL reset_src0 got=%h exp=%h", bus.oSRC_DATA[31:0], 32'h11);
        end
        checks++;
        if (bus.oSRC_HIT !== 2'b00) begin
            failures++; $display("FAIL reset_hit got=%b exp=00", bus.oSRC_HIT);
        end
        checks++;
        if (bus.oHIST_OCCUPIED !== 2'b00) begin
            failures++; $display("FAIL reset_occ got=%b exp=00", bus.oHIST_OCCUPIED);
        end
        checks++;
        if (bus.oSPR !== 32'h2222 || bus.oPSR !== 32'h0) begin
            failures++; $display("FAIL reset_spr_psr got=%h/%h exp=2222/0", bus.oSPR, bus.oPSR);
        end
        // current-stage writeback still forwards while reset is held
        gr_wb(5'd3, 32'h77, 0);
        bus.iADVANCE = 1;
        tick();
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h77 || bus.oSRC_HIT !== 2'b01) begin
            failures++; $display("FAIL reset_cur_wb got=%h hit=%b exp=77 hit=01", bus.oSRC_DATA[31:0], bus.oSRC_HIT);
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.oHIST_OCCUPIED !== 2'b00) begin
            failures++; $display("FAIL reset_no_capture got=%b exp=00", bus.oHIST_OCCUPIED);
        end
        rst_n = 1;
        $display("test_reset done");
    endtask

    task automatic test_forward();
        idle_inputs();
        set_src(0, 0, 5'd3, 32'h11);
        set_src(1, 0, 5'd4, 32'h44);
        gr_wb(5'd3, 32'hAA, 0);
        bus.iADVANCE = 1;
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'hAA || bus.oSRC_HIT !== 2'b01) begin
            failures++; $display("FAIL fwd_current got=%h hit=%b exp=aa hit=01", bus.oSRC_DATA[31:0], bus.oSRC_HIT);
        end
        tick();
        gr_wb(5'd3, 32'hBB, 0);
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'hBB) begin
            failures++; $display("FAIL fwd_cur_over_slot got=%h exp=bb", bus.oSRC_DATA[31:0]);
        end
        tick();
        bus.iWB_GR_VALID = 0;
        bus.iADVANCE = 0;
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'hBB || bus.oSRC_HIT !== 2'b01) begin
            failures++; $display("FAIL fwd_slot0_newest got=%h hit=%b exp=bb hit=01", bus.oSRC_DATA[31:0], bus.oSRC_HIT);
        end
        checks++;
        if (bus.oSRC_DATA[63:32] !== 32'h44 || bus.oHIST_OCCUPIED !== 2'b11) begin
            failures++; $display("FAIL fwd_src1_miss got=%h occ=%b exp=44 occ=11", bus.oSRC_DATA[63:32], bus.oHIST_OCCUPIED);
        end
        // pointer 0 is forwarded like any other register
        gr_wb(5'd0, 32'hCAFE, 0);
        set_src(1, 0, 5'd0, 32'h44);
        #1;
        checks++;
        if (bus.oSRC_DATA[63:32] !== 32'hCAFE || bus.oSRC_HIT !== 2'b11) begin
            failures++; $display("FAIL fwd_ptr0 got=%h hit=%b exp=cafe hit=11", bus.oSRC_DATA[63:32], bus.oSRC_HIT);
        end
        $display("test_forward done");
    endtask

    task automatic test_depth_expiry();
        sync_clear();
        set_src(0, 0, 5'd5, 32'h1234);
        gr_wb(5'd5, 32'h55, 0);
        bus.iADVANCE = 1;
        tick();
        bus.iWB_GR_VALID = 0;
        tick();
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h55 || bus.oSRC_HIT[0] !== 1'b1 || bus.oHIST_OCCUPIED !== 2'b10) begin
            failures++; $display("FAIL expiry_slot1 got=%h hit=%b occ=%b exp=55 hit=1 occ=10", bus.oSRC_DATA[31:0], bus.oSRC_HIT[0], bus.oHIST_OCCUPIED);
        end
        tick();
        bus.iADVANCE = 0;
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h1234 || bus.oSRC_HIT[0] !== 1'b0 || bus.oHIST_OCCUPIED !== 2'b00) begin
            failures++; $display("FAIL expiry_gone got=%h hit=%b occ=%b exp=1234 hit=0 occ=00", bus.oSRC_DATA[31:0], bus.oSRC_HIT[0], bus.oHIST_OCCUPIED);
        end
        $display("test_depth_expiry done");
    endtask

    task automatic test_frcr();
        sync_clear();
        gr_wb(FRCR2X, 32'hDEAD, 1);
        bus.iWB_FRCR_VALID = 1;
        bus.iWB_FRCR_DATA = 64'h12345678_9ABCDEF0;
        bus.iADVANCE = 1;
        tick();
        bus.iWB_GR_VALID = 0; bus.iWB_FRCR_VALID = 0;
        tick();
        bus.iADVANCE = 0;
        set_src(0, 1, FRCHR, 32'h1);
        set_src(1, 1, FRCLR, 32'h2);
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h12345678 || bus.oSRC_HIT[0] !== 1'b1) begin
            failures++; $display("FAIL frchr got=%h hit=%b exp=12345678 hit=1", bus.oSRC_DATA[31:0], bus.oSRC_HIT[0]);
        end
        checks++;
        if (bus.oSRC_DATA[63:32] !== 32'h9ABCDEF0 || bus.oSRC_HIT[1] !== 1'b1) begin
            failures++; $display("FAIL frclr got=%h hit=%b exp=9abcdef0 hit=1", bus.oSRC_DATA[63:32], bus.oSRC_HIT[1]);
        end
        bus.iSRC_IMM = 2'b11;
        #1;
        checks++;
        if (bus.oSRC_DATA !== {32'h2, 32'h1} || bus.oSRC_HIT !== 2'b00) begin
            failures++; $display("FAIL frcr_imm got=%h hit=%b exp=0000000200000001 hit=00", bus.oSRC_DATA, bus.oSRC_HIT);
        end
        // a GR source with the same pointer must not match a sysreg producer
        bus.iSRC_IMM = 2'b00;
        set_src(0, 0, FRCR2X, 32'h3);
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h3 || bus.oSRC_HIT[0] !== 1'b0) begin
            failures++; $display("FAIL frcr_gr_nomatch got=%h hit=%b exp=3 hit=0", bus.oSRC_DATA[31:0], bus.oSRC_HIT[0]);
        end
        $display("test_frcr done");
    endtask

    task automatic test_spr_psr();
        sync_clear();
        gr_wb(PSR, 32'h5, 1);
        bus.iADVANCE = 1;
        tick();
        idle_inputs();
        bus.iWB_SPR_VALID = 1; bus.iWB_SPR_DATA = 32'h1000;
        set_src(0, 1, SPR, 32'h77);
        #1;
        checks++;
        if (bus.oPSR !== 32'h5 || bus.oSPR !== 32'h1000) begin
            failures++; $display("FAIL psr_spr got=%h/%h exp=5/1000", bus.oPSR, bus.oSPR);
        end
        // current level has no GR valid and slot0's dest is PSR: no source match
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h77 || bus.oSRC_HIT[0] !== 1'b0) begin
            failures++; $display("FAIL spr_src_needs_gr got=%h hit=%b exp=77 hit=0", bus.oSRC_DATA[31:0], bus.oSRC_HIT[0]);
        end
        gr_wb(SPR, 32'hAAAA, 1);
        bus.iWB_SPR_VALID = 0; bus.iWB_SPR_DATA = 32'h3333;
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h3333 || bus.oSRC_HIT[0] !== 1'b1) begin
            failures++; $display("FAIL spr_src_dest got=%h hit=%b exp=3333 hit=1", bus.oSRC_DATA[31:0], bus.oSRC_HIT[0]);
        end
        // sync clear wins over advance and captures nothing
        bus.iWB_SPR_VALID = 1; bus.iWB_SPR_DATA = 32'h1000;
        bus.iRESET_SYNC = 1; bus.iADVANCE = 1;
        #1;
        checks++;
        if (bus.oSPR !== 32'h1000) begin
            failures++; $display("FAIL sync_cur_lookup got=%h exp=1000", bus.oSPR);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.oPSR !== 32'h0 || bus.oSPR !== 32'h2222 || bus.oHIST_OCCUPIED !== 2'b00) begin
            failures++; $display("FAIL sync_cleared got=%h/%h occ=%b exp=0/2222 occ=00", bus.oPSR, bus.oSPR, bus.oHIST_OCCUPIED);
        end
        $display("test_spr_psr done");
    endtask

    task automatic test_hold();
        logic [31:0] exp;
        sync_clear();
        gr_wb(5'd7, 32'h70, 0);
        bus.iADVANCE = 1;
        tick();
        idle_inputs();
        set_src(0, 0, 5'd7, 32'h99);
        for (int i = 0; i < 4; i++) begin
            bus.iWB_GR_VALID = i[0];
            bus.iWB_GR_DEST = 5'd7;
            bus.iWB_GR_DATA = 32'h100 + i;
            exp = i[0] ? 32'h100 + i : 32'h70;
            #1;
            checks++;
            if (bus.oSRC_DATA[31:0] !== exp || bus.oHIST_OCCUPIED !== 2'b01) begin
                failures++; $display("FAIL hold_cycle%0d got=%h occ=%b exp=%h occ=01", i, bus.oSRC_DATA[31:0], bus.oHIST_OCCUPIED, exp);
            end
            tick();
        end
        idle_inputs();
        set_src(0, 0, 5'd7, 32'h99);
        #1;
        checks++;
        if (bus.oSRC_DATA[31:0] !== 32'h70) begin
            failures++; $display("FAIL hold_final got=%h exp=70", bus.oSRC_DATA[31:0]);
        end
        $display("test_hold done");
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus.oHIST_OCCUPIED !== 2'b00 || bus.oSRC_DATA[31:0] !== 32'h99) begin
            failures++; $display("FAIL async_reset got occ=%b data=%h exp occ=00 data=99", bus.oHIST_OCCUPIED, bus.oSRC_DATA[31:0]);
        end
        rst_n = 1;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        tick();
        test_forward();
        tick();
        test_depth_expiry();
        test_frcr();
        test_spr_psr();
        test_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_forwarding_history.md
Name: execute_forwarding_history

Overview:
- Parametrised successor to the execute-stage operand forwarding unit.
- Keeps a P_DEPTH-deep shift history of writeback results: GR/sysreg data, SPR and 64-bit FRCR.
- Resolves P_SRC_NUM source operands in parallel, newest producer first, and also forwards SPR and PSR.
- Sits between the register-read latch and the ALU inputs. It covers the window in which writebacks have left execute but are not yet visible in the register file.

Parameters:
- P_DEPTH, 2, number of history slots (1..8); slot 0 is the newest.
- P_SRC_NUM, 2, number of source operands resolved per cycle (1..4).

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  asynchronous active-low reset.
- iRESET_SYNC  in  1  synchronous clear of all history valid bits.
- iADVANCE  in  1  shift history by one slot at this edge (pipeline not stalled).
- iWB_GR_VALID  in  1  current writeback of GR/sysreg.
- iWB_GR_DATA  in  32  current GR/sysreg data.
- iWB_GR_DEST  in  5  current destination pointer.
- iWB_GR_DEST_SYSREG  in  1  destination is a sysreg.
- iWB_SPR_VALID  in  1  current SPR writeback.
- iWB_SPR_DATA  in  32  current SPR data.
- iWB_FRCR_VALID  in  1  current FRCR writeback.
- iWB_FRCR_DATA  in  64  current FRCR data.
- iSRC_IMM  in  P_SRC_NUM  per-source immediate/settled flag (no forwarding).
- iSRC_SYSREG  in  P_SRC_NUM  per-source sysreg flag.
- iSRC_POINTER  in  5*P_SRC_NUM  per-source pointer, source k at bits [5k+4:5k].
- iSRC_DATA  in  32*P_SRC_NUM  per-source register-file data.
- iSRC_SPR  in  32  register-file SPR.
- iSRC_PSR  in  32  register-file PSR.
- oSRC_DATA  out  32*P_SRC_NUM  forwarded operands.
- oSRC_HIT  out  P_SRC_NUM  source k was forwarded.
- oSPR  out  32  forwarded SPR.
- oPSR  out  32  forwarded PSR.
- oHIST_OCCUPIED  out  P_DEPTH  per-slot valid (any of GR/SPR/FRCR valid).

Behaviour:
- Each slot holds gr_valid, gr_sysreg, gr_dest[4:0], gr_data[31:0], spr_valid, spr_data[31:0], frcr_valid and frcr_data[63:0].
- Reset (inRESET low, async): all valid bits 0. Data fields are don't-care; 0 is recommended. oHIST_OCCUPIED=0.
- Output values under reset follow the combinational rules with an empty history: oSRC_DATA=iSRC_DATA, oSPR=iSRC_SPR, oPSR=iSRC_PSR, unless the current-stage inputs hit.
- Posedge with iRESET_SYNC=1: all valid bits cleared. This takes priority over iADVANCE.
- Posedge with iADVANCE=1: slot i+1 <= slot i, and slot 0 <= the current iWB_* fields with their valid bits. The oldest slot is discarded.
- Posedge with iADVANCE=0: history holds. The current iWB_* inputs are still used for lookup but are not captured.
- Lookup is combinational with zero latency. The priority chain runs, highest first: current iWB_* inputs, slot 0, …, slot P_DEPTH-1, register-file data.
- Matching for source k, evaluated at each level whose gr_valid is set, skipped when iSRC_IMM[k]=1. Within a level, the first true rule wins:
  - (a) src sysreg, pointer==`SYSREG_SPR, and (spr_valid or gr_dest==`SYSREG_SPR): take spr_data.
  - (b) src sysreg, pointer==`SYSREG_FRCLR, gr_dest==`SYSREG_FRCR2FRCXR: take frcr_data[31:0].
  - (c) src sysreg, pointer==`SYSREG_FRCHR, gr_dest==`SYSREG_FRCR2FRCXR: take frcr_data[63:32].
  - (d) neither src nor level is sysreg and pointers are equal: take gr_data.
- oSRC_HIT[k]=1 iff any level matched.
- oSPR: the newest level with spr_valid supplies spr_data; otherwise iSRC_SPR.
- oPSR: the newest level with gr_valid, gr_sysreg and gr_dest==`SYSREG_PSR supplies gr_data; otherwise iSRC_PSR.
- A GR write to pointer 0 is forwarded like any other pointer; this block does not special-case it.
- Simultaneous iRESET_SYNC with a current writeback: lookup still uses the current inputs in that cycle, and nothing is captured.
- Reset asserted mid-operation: history is lost immediately. Upstream must replay or stall.

Test Plan:
- Reset, then src0 GR r3 with iSRC_DATA=0x11 and no writebacks -> oSRC_DATA[0]=0x11, oSRC_HIT=0, oHIST_OCCUPIED=0.
- Current writeback r3=0xAA with advance; next cycle slot0 r3=0xAA and current r3=0xBB -> src r3 gives 0xBB. Next cycle with no current writeback -> 0xBB from slot0.
- With P_DEPTH=2, write r5=0x55, advance 3 times with no writebacks -> src r5 returns iSRC_DATA and the hit clears after the third advance.
- Slot1 FRCR valid, gr_dest=`SYSREG_FRCR2FRCXR, data 0x12345678_9ABCDEF0 -> FRCHR source 0x12345678, FRCLR source 0x9ABCDEF0. With iSRC_IMM=1 -> iSRC_DATA is passed through.
- Slot0 sysreg PSR=0x5, iSRC_PSR=0x0, current spr_valid=0x1000 -> oPSR=0x5, oSPR=0x1000. Then iRESET_SYNC -> oPSR=0x0, oSPR=iSRC_SPR.
- iADVANCE=0 for 4 cycles with writebacks toggling -> history unchanged, and each cycle's current writeback is visible only in that cycle.
